// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter: FSM encoding, hold counter
// width and the index width helper used to size grant_index.
package edge_event_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int CNT_W = 8;

    // A single requester still needs a one-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/event_capture.sv
// Two-flop synchroniser per request line, rising-edge detect and sticky
// pending bits that collapse repeated edges until the arbiter clears them.
module event_capture #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [WIDTH-1:0] signal_in,
    input  logic [WIDTH-1:0] clear_mask,
    output logic [WIDTH-1:0] pending
);

    logic [WIDTH-1:0] ff0;
    logic [WIDTH-1:0] ff1;
    logic [1:0]       fill;
    logic [WIDTH-1:0] rise;

    // Both stages must hold real post-reset samples before an edge counts, so a
    // line held high across reset release fills ff0/ff1 high without an event.
    assign rise = fill[1] ? (ff0 & ~ff1) : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, as the synchroniser chain requires.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ff0     <= '0;
            ff1     <= '0;
            fill    <= 2'b00;
            pending <= '0;
        end else begin
            ff0     <= signal_in;
            ff1     <= ff0;
            fill    <= {fill[0], 1'b1};
            // A fresh edge wins over a clear arriving on the same posedge.
            pending <= (pending & ~clear_mask) | rise;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter granting captured rising-edge events one at a time to a
// shared consumer, releasing on done or after a bounded hold time.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         sync_reset,
    input  logic [WIDTH-1:0]             signal_in,
    input  logic                         done,
    output logic [WIDTH-1:0]             grant,
    output logic                         grant_valid,
    output logic [idx_width(WIDTH)-1:0]  grant_index,
    output logic [WIDTH-1:0]             pending,
    output logic                         timeout_flag
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    arb_state_t       state_q, state_n;
    logic [WIDTH-1:0] grant_n;
    logic [IDX_W-1:0] index_n;
    logic [IDX_W-1:0] last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             tflag_n;
    logic [WIDTH-1:0] clear_mask;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;

    event_capture #(.WIDTH(WIDTH)) u_capture (
        .clk        (clk),
        .sync_reset (sync_reset),
        .signal_in  (signal_in),
        .clear_mask (clear_mask),
        .pending    (pending)
    );

    // Round-robin search starting just after the last released requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 1; off <= WIDTH; off++) begin
            int cand;
            cand = int'(last_q) + off;
            if (cand >= WIDTH) cand = cand - WIDTH;
            if (!sel_found && pending[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n    = state_q;
        grant_n    = grant;
        index_n    = grant_index;
        last_n     = last_q;
        cnt_n      = cnt_q;
        tflag_n    = 1'b0;
        clear_mask = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_n    = ONE << sel_idx;
                    index_n    = sel_idx;
                    cnt_n      = '0;
                    clear_mask = ONE << sel_idx;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                if (done || cnt_q == CNT_LIMIT) begin
                    grant_n = '0;
                    index_n = '0;
                    last_n  = grant_index;
                    tflag_n = !done;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= IDLE;
            grant        <= '0;
            grant_index  <= '0;
            last_q       <= LAST_RST;
            cnt_q        <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state_q      <= state_n;
            grant        <= grant_n;
            grant_index  <= index_n;
            last_q       <= last_n;
            cnt_q        <= cnt_n;
            timeout_flag <= tflag_n;
        end
    end

    assign grant_valid = (state_q == BUSY);

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: number of requesters, 2..16.
REQ-002 Parameter TIMEOUT, default 15: maximum grant hold in cycles, 1..255.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 sync_reset  input  1  synchronous, active-high reset.
REQ-005 signal_in  input  WIDTH  level request lines, one per requester, asynchronous to clk.
REQ-006 done  input  1  consumer completion strobe for the current grant.
REQ-007 grant  output  WIDTH  one-hot grant to the shared consumer; all zero when no grant.
REQ-008 grant_valid  output  1  high exactly while grant is nonzero.
REQ-009 grant_index  output  clog2(WIDTH)  binary index of the granted requester; 0 when none.
REQ-010 pending  output  WIDTH  captured, not-yet-granted rising-edge events.
REQ-011 timeout_flag  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 Each signal_in bit SHALL pass through two flops (ff0, ff1); rising edge = ff0 & ~ff1.
REQ-013 A detected edge SHALL set its pending bit on the next posedge, so edge sampled at edge k gives pending high after edge k+1.
REQ-014 FSM states SHALL be IDLE and BUSY only.
REQ-015 IDLE with pending nonzero SHALL register the grant on the next posedge and enter BUSY, so grant is high after edge k+2 for an input first sampled at edge k.
REQ-016 Selection SHALL be round-robin: search from last_index+1 upward, wrapping at WIDTH-1 to 0.
REQ-017 last_index SHALL reset to WIDTH-1, so requester 0 wins first after reset.
REQ-018 The granted pending bit SHALL clear on the same posedge that issues the grant.
REQ-019 A new edge on a requester in the same cycle its pending bit is cleared SHALL leave the bit set; set wins.
REQ-020 Edges during BUSY, including one from the granted requester, SHALL set pending normally and SHALL NOT alter the active grant.
REQ-021 Multiple edges on one requester before it is granted SHALL collapse into one pending event.
REQ-022 BUSY SHALL hold grant, grant_index and grant_valid constant until done or timeout.
REQ-023 done high in BUSY SHALL clear grant and return to IDLE on that posedge; last_index takes the granted index.
REQ-024 done SHALL be ignored in IDLE.
REQ-025 The hold counter SHALL be 8 bits, zeroed when a grant is issued, and incremented each BUSY cycle without done.
REQ-026 When the counter reaches TIMEOUT-1 with done low, the next posedge SHALL clear grant, pulse timeout_flag, update last_index and enter IDLE; the event is dropped.
REQ-027 done and timeout in the same cycle SHALL count as done; no timeout_flag.
REQ-028 After any release, at least one IDLE cycle with grant_valid low SHALL occur before the next grant.

Reset
REQ-029 sync_reset high at posedge SHALL set: FSM IDLE; ff0, ff1 and pending all 0; grant 0; grant_valid 0; grant_index 0; timeout_flag 0; counter 0; last_index WIDTH-1.
REQ-030 sync_reset SHALL override done, edges and timeout in the same cycle.
REQ-031 Reset asserted mid-grant SHALL drop the grant without a timeout_flag pulse.
REQ-032 A signal_in held high through reset release SHALL produce no event: ff0 and ff1 both fill high, so no rising edge is seen.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE, BUSY), the counter width constant (8) and the index width function.
REQ-034 Edge capture (REQ-012, REQ-013, REQ-019, REQ-021) SHALL be one sub-module, event_capture, parameterised by WIDTH with inputs clk, sync_reset, signal_in and clear mask; output pending.
REQ-035 The round-robin selector SHALL be combinational inside edge_event_arbiter.

Verification
REQ-036 Reset, then pulse signal_in[2] for 3 cycles -> pending[2] after edge k+1; grant=4'b0100 and grant_index=2 after edge k+2; done -> grant 0 next cycle.
REQ-037 signal_in=4'b1111 rising together, done 1 cycle after each grant -> grant order 0,1,2,3, each separated by one idle cycle.
REQ-038 Grant requester 1 and never assert done, TIMEOUT=15 -> grant held exactly 15 cycles, then timeout_flag for 1 cycle and pending[1]=0.
REQ-039 Requester 3 re-edges during its own grant and again in the grant-issue cycle -> pending[3]=1, a single further grant to 3 after done.
REQ-040 sync_reset mid-grant with signal_in[0] held high -> all outputs 0 next cycle, timeout_flag 0, no grant after reset release until signal_in[0] falls and rises again.
REQ-041 done and timeout coincide at counter=TIMEOUT-1 -> normal release, timeout_flag stays 0.
